// File: rtl/eeprom_log_pkg.sv
// Shared types and constants for the data-logger ADC sequencing path.
// Includes the divider clamp used when a new frame latches its sclk period.
package eeprom_log_pkg;

  localparam int unsigned MIN_DIV = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned DIV_W   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } seq_state_t;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] cfg);
    if (cfg < DIV_W'(MIN_DIV)) begin
      return DIV_W'(MIN_DIV);
    end else begin
      return cfg;
    end
  endfunction

endpackage

// File: rtl/adc_sample_sequencer_sclk_gen.sv
// Runtime-programmable serial clock divider: latches the clamped period at frame
// start, runs the phase counter and produces rise/end strobes and a registered sclk.
module sclk_gen
  import eeprom_log_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_cfg_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             shift_next_i,
  output logic             rise_o,
  output logic             end_o,
  output logic             sclk_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] half_s;
  logic             sclk_q;

  assign half_s = div_q >> 1;
  assign rise_o = run_i && (cnt_q == half_s);
  assign end_o  = run_i && (cnt_q == (div_q - DIV_W'(1)));
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d = '0;
    if (run_i && !end_o) begin
      cnt_d = cnt_q + DIV_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // sclk is derived from the next phase so that it lines up with cnt_q; the
  // divisor is never reloaded on an edge that keeps the frame shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= DIV_W'(MIN_DIV);
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      if (load_i) begin
        div_q <= clamp_div(div_cfg_i);
      end
      cnt_q  <= cnt_d;
      sclk_q <= shift_next_i && (cnt_d >= half_s);
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Serial ADC conversion sequencer: frames conversions with chip-select, round-robins
// channels and hands samples to the EEPROM path through a one-deep holding register.
module adc_sample_sequencer
  import eeprom_log_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned GAP_PER = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_cfg,
  output logic              adc_sclk,
  output logic              adc_cs_n,
  output logic [CH_W-1:0]   adc_ch,
  input  logic              adc_din,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              busy
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned GAP_W = $clog2(GAP_PER + 1);

  seq_state_t        state_q;
  logic [BIT_W-1:0]  bit_q;
  logic [GAP_W-1:0]  gap_q;
  logic [CH_W-1:0]   chan_q;
  logic [CH_W-1:0]   adc_ch_q;
  logic [DATA_W-1:0] shift_q;
  logic              cs_n_q;
  logic              busy_q;
  logic [DATA_W-1:0] sample_data_q;
  logic [CH_W-1:0]   sample_ch_q;
  logic              valid_q;
  logic              overrun_q;

  logic rise_s;
  logic end_s;
  logic sclk_s;
  logic run_s;
  logic bit_last_s;
  logic gap_last_s;
  logic start_go_s;
  logic shift_next_s;
  logic drop_s;

  assign run_s        = (state_q == START) || (state_q == SHIFT) || (state_q == GAP);
  assign bit_last_s   = (bit_q == BIT_W'(DATA_W - 1));
  assign gap_last_s   = (gap_q == GAP_W'(GAP_PER - 1));
  assign start_go_s   = enable && ((state_q == IDLE) ||
                                   ((state_q == GAP) && end_s && gap_last_s));
  assign shift_next_s = ((state_q == START) && end_s) ||
                        ((state_q == SHIFT) && !(end_s && bit_last_s));
  assign drop_s       = (state_q == DONE) && valid_q && !sample_ready;

  sclk_gen u_sclk_gen (
    .clk          (clk),
    .rst          (rst),
    .div_cfg_i    (div_cfg),
    .load_i       (start_go_s),
    .run_i        (run_s),
    .shift_next_i (shift_next_s),
    .rise_o       (rise_s),
    .end_o        (end_s),
    .sclk_o       (sclk_s)
  );

  // Conversion FSM; chip-select, busy and channel address are set on the transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      gap_q    <= '0;
      chan_q   <= '0;
      adc_ch_q <= '0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_go_s) begin
            state_q  <= START;
            cs_n_q   <= 1'b0;
            adc_ch_q <= chan_q;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (end_s) begin
            state_q <= SHIFT;
            bit_q   <= '0;
          end
        end
        SHIFT: begin
          if (rise_s) begin
            shift_q <= {shift_q[DATA_W-2:0], adc_din};
          end
          if (end_s) begin
            if (bit_last_s) begin
              state_q <= DONE;
              cs_n_q  <= 1'b1;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= GAP;
          gap_q   <= '0;
          chan_q  <= (chan_q == CH_W'(NUM_CH - 1)) ? '0 : chan_q + CH_W'(1);
        end
        GAP: begin
          if (end_s) begin
            if (!gap_last_s) begin
              gap_q <= gap_q + GAP_W'(1);
            end else if (start_go_s) begin
              state_q  <= START;
              cs_n_q   <= 1'b0;
              adc_ch_q <= chan_q;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: a load in DONE may coincide with the consumer draining it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_data_q <= '0;
      sample_ch_q   <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (state_q == DONE) begin
        if (!valid_q || sample_ready) begin
          sample_data_q <= shift_q;
          sample_ch_q   <= chan_q;
          valid_q       <= 1'b1;
        end
      end else if (valid_q && sample_ready) begin
        valid_q <= 1'b0;
      end
      if (drop_s) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign adc_sclk     = sclk_s;
  assign adc_cs_n     = cs_n_q;
  assign adc_ch       = adc_ch_q;
  assign busy         = busy_q;
  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer with a behavioural serial ADC that
// returns a fixed byte per channel, MSB first, updating on sclk falling edges.
module tb_adc_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] div_cfg;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic [1:0]  adc_ch;
  logic        adc_din;
  logic [7:0]  sample_data;
  logic [1:0]  sample_ch;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        overrun_clr;
  logic        busy;

  logic [7:0] pat [0:3] = '{8'hA5, 8'h3C, 8'h0F, 8'hF1};

  int total = 0;
  int bad   = 0;

  adc_sample_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .div_cfg      (div_cfg),
    .adc_sclk     (adc_sclk),
    .adc_cs_n     (adc_cs_n),
    .adc_ch       (adc_ch),
    .adc_din      (adc_din),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ADC model: MSB valid once chip-select falls, next bit after each sclk fall.
  initial begin
    logic [7:0] sr;
    adc_din = 1'b0;
    forever begin
      @(negedge adc_cs_n);
      #1;
      sr = pat[adc_ch];
      adc_din = sr[7];
      for (int b = 1; b < 8; b++) begin
        @(negedge adc_sclk or posedge adc_cs_n);
        if (adc_cs_n) break;
        sr = {sr[6:0], 1'b0};
        adc_din = sr[7];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs_low();
    int g;
    g = 0;
    while (adc_cs_n !== 1'b0 && g < 400) begin
      step();
      g++;
    end
    chk("cs_fall_wait", 32'(adc_cs_n), 32'd0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 400) begin
      step();
      g++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  // Runs to the end of the next frame; drives ready/clr during the DONE cycle.
  task automatic wait_frame_end(input logic rdy_done, input logic clr_done);
    int g;
    wait_cs_low();
    g = 0;
    while (adc_cs_n !== 1'b1 && g < 400) begin
      step();
      g++;
    end
    chk("cs_rise_wait", 32'(adc_cs_n), 32'd1);
    sample_ready = rdy_done;
    overrun_clr  = clr_done;
    step();
    overrun_clr  = 1'b0;
  endtask

  // Measures START entry -> sample_valid latency and sclk shape; optionally
  // changes div_cfg/enable at cycle act_at of the frame.
  task automatic measure(input int act_at, input logic [15:0] act_div, input logic act_en,
                         output int n, output int rises, output int hmin, output int hmax);
    int   run;
    logic prev;
    wait_cs_low();
    n = 0; rises = 0; hmin = 999; hmax = 0; run = 0;
    prev = adc_sclk;
    while (sample_valid !== 1'b1 && n < 400) begin
      step();
      n++;
      if (n == act_at) begin
        div_cfg = act_div;
        enable  = act_en;
      end
      if (adc_sclk) begin
        if (!prev) rises++;
        run++;
      end else if (prev) begin
        if (run < hmin) hmin = run;
        if (run > hmax) hmax = run;
        run = 0;
      end
      prev = adc_sclk;
    end
  endtask

  initial begin
    int n, r, hmn, hmx, falls;
    rst = 1'b1; enable = 1'b0; div_cfg = 16'd8; sample_ready = 1'b1; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n",  32'(adc_cs_n),     32'd1);
    chk("rst_sclk",  32'(adc_sclk),     32'd0);
    chk("rst_ch",    32'(adc_ch),       32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_data",  32'(sample_data),  32'd0);
    chk("rst_sch",   32'(sample_ch),    32'd0);
    chk("rst_ovr",   32'(overrun),      32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // First frame at div 8 on channel 0
    enable = 1'b1;
    measure(0, 16'd8, 1'b1, n, r, hmn, hmx);
    chk("t2_latency", n, 32'd73);
    chk("t2_rises",   r, 32'd8);
    chk("t2_hmin",    hmn, 32'd4);
    chk("t2_hmax",    hmx, 32'd4);
    chk("t2_data",    32'(sample_data), 32'hA5);
    chk("t2_ch",      32'(sample_ch),   32'd0);

    // Round-robin with wrap back to channel 0
    for (int i = 1; i <= 4; i++) begin
      measure(0, 16'd8, 1'b1, n, r, hmn, hmx);
      chk("t3_ch",   32'(sample_ch),   32'(i % 4));
      chk("t3_data", 32'(sample_data), 32'(pat[i % 4]));
    end

    // Stalled consumer: hold first, drop second, then clear
    step();
    chk("t4_drained", 32'(sample_valid), 32'd0);
    sample_ready = 1'b0;
    wait_frame_end(1'b0, 1'b0);
    chk("t4a_valid", 32'(sample_valid), 32'd1);
    chk("t4a_data",  32'(sample_data),  32'(pat[1]));
    chk("t4a_ch",    32'(sample_ch),    32'd1);
    chk("t4a_ovr",   32'(overrun),      32'd0);
    wait_frame_end(1'b0, 1'b0);
    chk("t4b_valid", 32'(sample_valid), 32'd1);
    chk("t4b_data",  32'(sample_data),  32'(pat[1]));
    chk("t4b_ch",    32'(sample_ch),    32'd1);
    chk("t4b_ovr",   32'(overrun),      32'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("t4_clr", 32'(overrun), 32'd0);
    wait_frame_end(1'b0, 1'b1);
    chk("t4_set_wins", 32'(overrun),     32'd1);
    chk("t4c_data",    32'(sample_data), 32'(pat[1]));
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("t4_clr2", 32'(overrun), 32'd0);

    // Ready only in the DONE cycle: accept and reload, no overrun
    wait_frame_end(1'b1, 1'b0);
    chk("t5_valid", 32'(sample_valid), 32'd1);
    chk("t5_data",  32'(sample_data),  32'(pat[0]));
    chk("t5_ch",    32'(sample_ch),    32'd0);
    chk("t5_ovr",   32'(overrun),      32'd0);

    // Divider clamp, mid-frame reconfiguration, enable drop
    enable = 1'b0;
    wait_idle();
    chk("t6_idle_cs", 32'(adc_cs_n), 32'd1);
    sample_ready = 1'b1;
    div_cfg = 16'd2;
    enable  = 1'b1;
    measure(2, 16'd8, 1'b1, n, r, hmn, hmx);
    chk("t6_clamp_latency", n, 32'd37);
    chk("t6_clamp_rises",   r, 32'd8);
    chk("t6_clamp_hmin",    hmn, 32'd2);
    chk("t6_clamp_hmax",    hmx, 32'd2);
    chk("t6_clamp_data",    32'(sample_data), 32'(pat[1]));
    chk("t6_clamp_ch",      32'(sample_ch),   32'd1);
    measure(20, 16'd16, 1'b1, n, r, hmn, hmx);
    chk("t6_div8_latency",  n, 32'd73);
    chk("t6_div8_hmax",     hmx, 32'd4);
    chk("t6_div8_data",     32'(sample_data), 32'(pat[2]));
    measure(40, 16'd16, 1'b0, n, r, hmn, hmx);
    chk("t6_div16_latency", n, 32'd145);
    chk("t6_div16_hmin",    hmn, 32'd8);
    chk("t6_div16_rises",   r, 32'd8);
    chk("t6_div16_data",    32'(sample_data), 32'(pat[3]));
    chk("t6_div16_ch",      32'(sample_ch),   32'd3);
    wait_idle();
    falls = 0;
    repeat (200) begin
      step();
      if (adc_cs_n === 1'b0) falls++;
    end
    chk("t6_stays_idle", falls, 32'd0);

    // Reset in the middle of a shift with a sample held
    sample_ready = 1'b0;
    enable = 1'b1;
    wait_frame_end(1'b0, 1'b0);
    chk("t1_held_valid", 32'(sample_valid), 32'd1);
    chk("t1_held_data",  32'(sample_data),  32'(pat[0]));
    wait_cs_low();
    repeat (30) step();
    chk("t1_pre_sclk", 32'(adc_sclk), 32'd1);
    chk("t1_pre_ch",   32'(adc_ch),   32'd1);
    rst = 1'b1;
    #1;
    chk("t1_cs_n",  32'(adc_cs_n),     32'd1);
    chk("t1_sclk",  32'(adc_sclk),     32'd0);
    chk("t1_valid", 32'(sample_valid), 32'd0);
    chk("t1_busy",  32'(busy),         32'd0);
    chk("t1_data",  32'(sample_data),  32'd0);
    step();
    rst = 1'b0;
    chk("t1_rel_ch", 32'(adc_ch), 32'd0);
    measure(0, 16'd16, 1'b1, n, r, hmn, hmx);
    chk("t1_restart_latency", n, 32'd145);
    chk("t1_restart_ch",      32'(sample_ch),   32'd0);
    chk("t1_restart_data",    32'(sample_data), 32'(pat[0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
